// File: rtl/ghost_mode_scheduler_if.sv
// Control and status bundle between the game core and the ghost mode scheduler.
// The game core is the master; the scheduler is the slave.
interface ghost_mode_scheduler_if;
  logic       start;
  logic       pause;
  logic       powerPellet;
  logic       isScatter;
  logic       isChase;
  logic       isFrightened;
  logic       frightFlash;
  logic       reversePulse;
  logic [2:0] phaseIdx;
  logic       gameTick;

  modport master (
    output start, pause, powerPellet,
    input  isScatter, isChase, isFrightened, frightFlash, reversePulse, phaseIdx, gameTick
  );

  modport slave (
    input  start, pause, powerPellet,
    output isScatter, isChase, isFrightened, frightFlash, reversePulse, phaseIdx, gameTick
  );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// Global ghost mode sequencer: 60 Hz tick divider, scatter/chase phase schedule
// and a power-pellet frightened override that freezes the phase timer.
module ghost_mode_scheduler #(
  parameter int TICK_DIV   = 416_666,
  parameter int SCAT_LONG  = 420,
  parameter int SCAT_SHORT = 300,
  parameter int CHASE_LEN  = 1200,
  parameter int FRIGHT_LEN = 360,
  parameter int FLASH_LEN  = 120
) (
  input logic                  clk,
  input logic                  reset,
  ghost_mode_scheduler_if.slave bus
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCATTER = 2'd1,
    CHASE   = 2'd2,
    FRIGHT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       phase_q, phase_d;
  logic [2:0]       next_phase_s;
  logic [11:0]      ptmr_q, ptmr_d;
  logic [11:0]      ftmr_q, ftmr_d;
  logic             tick_s;
  logic             rev_d;
  logic             flash_d;
  logic             scat_q, chase_q, fright_q, flash_q, rev_q, tick_q;

  // Phase 7 is endless chase, so its length is never consumed.
  function automatic logic [11:0] phase_len(input logic [2:0] idx);
    logic [11:0] len;
    case (idx)
      3'd0, 3'd2:       len = 12'(SCAT_LONG);
      3'd4, 3'd6:       len = 12'(SCAT_SHORT);
      3'd1, 3'd3, 3'd5: len = 12'(CHASE_LEN);
      default:          len = 12'd0;
    endcase
    return len;
  endfunction

  // Game tick divider, frozen in IDLE and while paused.
  always_comb begin
    tick_s = 1'b0;
    div_d  = div_q;
    if ((state_q != IDLE) && !bus.pause) begin
      if (div_q == DIV_W'(TICK_DIV - 1)) begin
        div_d  = '0;
        tick_s = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end else begin
      div_d = div_q;
    end
  end

  // Mode sequencing; a pellet always beats a coincident phase or fright expiry.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    ptmr_d       = ptmr_q;
    ftmr_d       = ftmr_q;
    rev_d        = 1'b0;
    next_phase_s = phase_q + 3'd1;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCATTER;
          phase_d = 3'd0;
          ptmr_d  = phase_len(3'd0);
        end else begin
          state_d = IDLE;
        end
      end
      SCATTER, CHASE: begin
        if (bus.powerPellet) begin
          state_d = FRIGHT;
          ftmr_d  = 12'(FRIGHT_LEN);
          rev_d   = 1'b1;
        end else if (tick_s && (phase_q != 3'd7)) begin
          if (ptmr_q == 12'd1) begin
            phase_d = next_phase_s;
            ptmr_d  = phase_len(next_phase_s);
            state_d = next_phase_s[0] ? CHASE : SCATTER;
            rev_d   = 1'b1;
          end else begin
            ptmr_d = ptmr_q - 12'd1;
          end
        end else begin
          ptmr_d = ptmr_q;
        end
      end
      FRIGHT: begin
        if (bus.powerPellet) begin
          ftmr_d = 12'(FRIGHT_LEN);
        end else if (tick_s) begin
          if (ftmr_q == 12'd1) begin
            state_d = phase_q[0] ? CHASE : SCATTER;
          end else begin
            ftmr_d = ftmr_q - 12'd1;
          end
        end else begin
          ftmr_d = ftmr_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    flash_d = (state_d == FRIGHT) && (ftmr_d <= 12'(FLASH_LEN));
  end

  // State, timers and output flops decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      phase_q  <= 3'd0;
      ptmr_q   <= 12'd0;
      ftmr_q   <= 12'd0;
      scat_q   <= 1'b0;
      chase_q  <= 1'b0;
      fright_q <= 1'b0;
      flash_q  <= 1'b0;
      rev_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      ptmr_q   <= ptmr_d;
      ftmr_q   <= ftmr_d;
      scat_q   <= (state_d == SCATTER);
      chase_q  <= (state_d == CHASE);
      fright_q <= (state_d == FRIGHT);
      flash_q  <= flash_d;
      rev_q    <= rev_d;
      tick_q   <= tick_s;
    end
  end

  assign bus.isScatter    = scat_q;
  assign bus.isChase      = chase_q;
  assign bus.isFrightened = fright_q;
  assign bus.frightFlash  = flash_q;
  assign bus.reversePulse = rev_q;
  assign bus.phaseIdx     = phase_q;
  assign bus.gameTick     = tick_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Scoreboard bench for ghost_mode_scheduler: a tick-level reference model predicts
// every clock's outputs, a monitor compares them, plus directed schedule checks.
module tb_ghost_mode_scheduler;
  localparam int TD = 4;
  localparam int SL = 3;
  localparam int SS = 2;
  localparam int CL = 5;
  localparam int FL = 6;
  localparam int FLASH = 2;

  typedef struct packed {
    logic       scat;
    logic       chase;
    logic       fright;
    logic       flash;
    logic       rev;
    logic [2:0] phase;
    logic       tick;
  } exp_t;

  logic clk;
  logic reset;
  ghost_mode_scheduler_if bus();

  ghost_mode_scheduler #(
    .TICK_DIV(TD), .SCAT_LONG(SL), .SCAT_SHORT(SS),
    .CHASE_LEN(CL), .FRIGHT_LEN(FL), .FLASH_LEN(FLASH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: mode 0 idle, 1 scatter, 2 chase, 3 frightened.
  int lens[8] = '{SL, CL, SL, CL, SS, CL, SS, 0};
  int m_mode = 0;
  int m_phase = 0;
  int m_left = 0;
  int m_fleft = 0;
  int m_div = 0;

  function automatic exp_t dut_out();
    exp_t a;
    a = {bus.isScatter, bus.isChase, bus.isFrightened, bus.frightFlash,
         bus.reversePulse, bus.phaseIdx, bus.gameTick};
    return a;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic model_step(input bit st, input bit pa, input bit pp, input bit rs, output exp_t e);
    bit tick;
    bit rev;
    tick = 1'b0;
    rev  = 1'b0;
    if (rs) begin
      m_mode = 0; m_phase = 0; m_left = 0; m_fleft = 0; m_div = 0;
      e = '0;
      return;
    end
    if (m_mode != 0 && !pa) begin
      tick  = (m_div == TD - 1);
      m_div = (m_div + 1) % TD;
    end
    if (m_mode == 0) begin
      if (st) begin
        m_mode = 1; m_phase = 0; m_left = lens[0];
      end
    end else if (m_mode == 3) begin
      if (pp) m_fleft = FL;
      else if (tick) begin
        m_fleft--;
        if (m_fleft == 0) m_mode = (m_phase % 2 == 1) ? 2 : 1;
      end
    end else begin
      if (pp) begin
        m_mode = 3; m_fleft = FL; rev = 1'b1;
      end else if (tick && m_phase < 7) begin
        m_left--;
        if (m_left == 0) begin
          m_phase++;
          m_left = lens[m_phase];
          m_mode = (m_phase % 2 == 1) ? 2 : 1;
          rev = 1'b1;
        end
      end
    end
    e.scat   = (m_mode == 1);
    e.chase  = (m_mode == 2);
    e.fright = (m_mode == 3);
    e.flash  = (m_mode == 3) && (m_fleft <= FLASH);
    e.rev    = rev;
    e.phase  = 3'(m_phase);
    e.tick   = tick;
  endtask

  // Drive one clock of stimulus and queue the predicted response.
  task automatic step(input bit st, input bit pa, input bit pp, input bit rs);
    exp_t e;
    @(negedge clk);
    bus.start = st; bus.pause = pa; bus.powerPellet = pp; reset = rs;
    model_step(st, pa, pp, rs, e);
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic step_obs(input bit st, input bit pa, input bit pp, input bit rs);
    step(st, pa, pp, rs);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every clock's outputs against the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    exp_t a;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = dut_out();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d got %b want %b (scat chase fright flash rev phase tick)",
                 cyc, a, e);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int revs;
    int ticks;
    int fticks;
    bit found;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.powerPellet = 1'b0;

    // Reset state and pellet ignored in IDLE.
    step_obs(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_outputs", int'(dut_out()), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step_obs(1'b0, 1'b0, 1'b1, 1'b0);
    step_obs(1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_pellet", int'(dut_out()), 0);

    // Tick spacing with a 10-clock pause.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step_obs(1'b0, 1'b0, 1'b0, 1'b0);
      found = bus.gameTick;
    end
    check("first_tick_seen", int'(found), 1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    n = 10;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step_obs(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
      found = bus.gameTick;
    end
    check("paused_tick_spacing", n, TD + 10);

    // Full schedule: seven reversals, then endless chase in phase 7.
    do_reset();
    step_obs(1'b1, 1'b0, 1'b0, 1'b0);
    revs = 0;
    for (int i = 0; i < 160; i++) begin
      step_obs(1'b0, 1'b0, 1'b0, 1'b0);
      revs += int'(bus.reversePulse);
    end
    check("schedule_reversals", revs, 7);
    check("schedule_final_phase", int'(bus.phaseIdx), 7);
    check("schedule_final_chase", int'(bus.isChase), 1);

    // Pellet in phase 1 with four ticks left.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300 && !(m_mode == 2 && m_phase == 1 && m_left == 4); i++)
      step(1'b0, 1'b0, 1'b0, 1'b0);
    step_obs(1'b0, 1'b0, 1'b1, 1'b0);
    revs = int'(bus.reversePulse);
    ticks = 0;
    fticks = 0;
    for (int i = 0; i < 200 && bus.isFrightened; i++) begin
      step_obs(1'b0, 1'b0, 1'b0, 1'b0);
      revs += int'(bus.reversePulse);
      if (bus.gameTick) begin
        ticks++;
        fticks += int'(bus.frightFlash);
      end
    end
    check("fright_ticks", ticks, FL);
    check("flash_ticks", fticks, FLASH);
    check("fright_reversals", revs, 1);
    check("resume_chase", int'(bus.isChase), 1);
    ticks = 0;
    for (int i = 0; i < 200 && bus.phaseIdx != 3'd2; i++) begin
      step_obs(1'b0, 1'b0, 1'b0, 1'b0);
      ticks += int'(bus.gameTick);
    end
    check("resumed_chase_ticks", ticks, 4);

    // Second pellet three ticks into fright.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step_obs(1'b0, 1'b0, 1'b1, 1'b0);
    revs = int'(bus.reversePulse);
    ticks = 0;
    for (int i = 0; i < 200 && bus.isFrightened; i++) begin
      step_obs(1'b0, 1'b0, (ticks == 3) && (n != -1), 1'b0);
      if (ticks == 3) n = -1;
      revs += int'(bus.reversePulse);
      ticks += int'(bus.gameTick);
    end
    check("reloaded_fright_ticks", ticks, FL + 3);
    check("reloaded_fright_reversals", revs, 1);

    // Pellet on the clock of a phase-1 expiring tick.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300 && !(m_mode == 2 && m_phase == 1 && m_left == 1 && m_div == TD - 1); i++)
      step(1'b0, 1'b0, 1'b0, 1'b0);
    step_obs(1'b0, 1'b0, 1'b1, 1'b0);
    check("collide_fright", int'(bus.isFrightened), 1);
    check("collide_phase", int'(bus.phaseIdx), 1);
    check("collide_reverse", int'(bus.reversePulse), 1);
    for (int i = 0; i < 200 && bus.isFrightened; i++) step_obs(1'b0, 1'b0, 1'b0, 1'b0);
    ticks = 0;
    for (int i = 0; i < 200 && bus.phaseIdx != 3'd2; i++) begin
      step_obs(1'b0, 1'b0, 1'b0, 1'b0);
      ticks += int'(bus.gameTick);
    end
    check("collide_chase_ticks", ticks, 1);
    check("collide_then_scatter", int'(bus.isScatter), 1);

    // Reset in the middle of fright, then pellet in IDLE.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step_obs(1'b0, 1'b0, 1'b0, 1'b1);
    check("mid_fright_reset", int'(dut_out()), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step_obs(1'b0, 1'b0, 1'b1, 1'b0);
    step_obs(1'b0, 1'b0, 1'b0, 1'b0);
    check("post_reset_pellet", int'(dut_out()), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 999) < 20, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 3, $urandom_range(0, 999) < 3);
    end

    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
